// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the iterative multiply unit: FSM state encoding,
// default sizes and the MUL instruction decode constants used by the main
// decoder. Optional early termination is enabled with MUL_EARLY_TERM_EN.
package mul_sequencer_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_CNT_W = 6;

    // MUL/MULS encoding: Op=00, Funct[25:24]=00, Instr[7:4]=1001
    localparam logic [1:0] MUL_OP         = 2'b00;
    localparam logic [1:0] MUL_FUNCT_HI   = 2'b00;
    localparam logic [3:0] MUL_INSTR_7_4  = 4'b1001;

    // Recognise a multiply in a 32-bit ARM instruction word.
    function automatic logic is_mul_instr(input logic [31:0] instr);
        return (instr[27:26] == MUL_OP) &&
               (instr[25:24] == MUL_FUNCT_HI) &&
               (instr[7:4]   == MUL_INSTR_7_4);
    endfunction

endpackage

// File: rtl/mul_datapath.sv
// Shift-add datapath: multiplicand, multiplier and accumulator registers
// with a single adder. 'load' captures new operands, 'step' performs one
// iteration. acc_next/mplier_next expose the values one step would produce
// so the sequencer can latch the result on the completing edge.
import mul_sequencer_pkg::*;

module mul_datapath #(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] mplier_next
);

    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;

    // One iteration: add the multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_next    = acc_r;
        mplier_next = mplier_r >> 1;
        if (mplier_r[0]) begin
            acc_next = acc_r + mcand_r;
        end else begin
            acc_next = acc_r;
        end
    end

    // Operand capture on load, shift/accumulate on step, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
        end else if (load) begin
            mcand_r  <= src_a;
            mplier_r <= src_b;
            acc_r    <= '0;
        end else if (step) begin
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_next;
            acc_r    <= acc_next;
        end else begin
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            acc_r    <= acc_r;
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// Iterative multiply unit for the multicycle core: FSM, iteration counter
// and registered Busy/Done/Product/MulFlags. Fixed WIDTH-iteration latency
// by default; define MUL_EARLY_TERM_EN to finish as soon as the remaining
// multiplier bits are all zero.
import mul_sequencer_pkg::*;

module mul_sequencer #(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Product,
    output logic [1:0]       MulFlags
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mul_state_t       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             load_s;
    logic             step_s;
    logic             last_s;
    logic [WIDTH-1:0] acc_next_s;
    logic [WIDTH-1:0] mplier_next_s;

    mul_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk         (clk),
        .reset       (reset),
        .load        (load_s),
        .step        (step_s),
        .src_a       (SrcA),
        .src_b       (SrcB),
        .acc_next    (acc_next_s),
        .mplier_next (mplier_next_s)
    );

    // Datapath controls and the "this edge completes the multiply" decision.
    always_comb begin
        load_s = 1'b0;
        step_s = 1'b0;
        last_s = 1'b0;
        if ((state_r == MUL_IDLE) || (state_r == MUL_DONE)) begin
            load_s = Start;
        end else begin
            load_s = 1'b0;
        end
        if (state_r == MUL_RUN) begin
            step_s = 1'b1;
`ifdef MUL_EARLY_TERM_EN
            last_s = (cnt_r == LAST_CNT) || (mplier_next_s == '0);
`else
            last_s = (cnt_r == LAST_CNT);
`endif
        end else begin
            step_s = 1'b0;
            last_s = 1'b0;
        end
    end

    // Control FSM with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= MUL_IDLE;
            cnt_r    <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Product  <= '0;
            MulFlags <= 2'b01;
        end else begin
            case (state_r)
                MUL_IDLE, MUL_DONE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        cnt_r <= '0;
`ifdef MUL_EARLY_TERM_EN
                        if (SrcB == '0) begin
                            // Zero multiplier: the result is known immediately.
                            state_r  <= MUL_DONE;
                            Busy     <= 1'b0;
                            Done     <= 1'b1;
                            Product  <= '0;
                            MulFlags <= 2'b01;
                        end else begin
                            state_r <= MUL_RUN;
                            Busy    <= 1'b1;
                        end
`else
                        state_r <= MUL_RUN;
                        Busy    <= 1'b1;
`endif
                    end else begin
                        state_r <= MUL_IDLE;
                        Busy    <= 1'b0;
                    end
                end
                MUL_RUN: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        state_r  <= MUL_DONE;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        Product  <= acc_next_s;
                        MulFlags <= {acc_next_s[WIDTH-1], ~|acc_next_s};
                    end else begin
                        state_r <= MUL_RUN;
                        Busy    <= 1'b1;
                        Done    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= MUL_IDLE;
                    cnt_r   <= '0;
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
